pulse_train_sequencer: RTL
==========================

# pulse_train_sequencer

Controller that sequences the square-wave pulse generator. Issues single-cycle START strobes to the generator at a programmable period, for a programmed number of pulses or continuously, triggered by software command or by an external trigger edge with holdoff. Sits between the register/command interface and the generator's START input, and reports run status back to the control registers.

## Interface

- PERIOD_WIDTH, 32, width of period/holdoff counter (cycles)
- COUNT_WIDTH, 16, width of pulse-count configuration and counter

- CLK  in  1  system clock (100 MHz)
- RST  in  1  synchronous, active-high reset
- CFG_PERIOD  in  PERIOD_WIDTH  internal mode: cycles between strobes; external mode: holdoff after each strobe; 0 treated as 1
- CFG_COUNT  in  COUNT_WIDTH  pulses per run; 0 = continuous
- CFG_EXT  in  1  0 = internal timer, 1 = external trigger
- CMD_START  in  1  one-cycle run request
- CMD_STOP  in  1  one-cycle abort
- EXT_TRIG  in  1  external trigger level, already synchronous to CLK
- WG_START  out  1  one-cycle strobe to pulse generator START
- BUSY  out  1  high while a run is active
- DONE  out  1  one-cycle strobe on normal completion
- PULSE_CNT  out  COUNT_WIDTH  strobes issued in current/last run

## Operation

- States: IDLE, RUN_INT, ARMED, HOLDOFF.
- IDLE: on CMD_START (and no CMD_STOP) latch CFG_PERIOD, CFG_COUNT, CFG_EXT; clear PULSE_CNT; go RUN_INT (CFG_EXT=0) or ARMED (CFG_EXT=1). Config changes after latching ignored until next run.
- RUN_INT: timer counts 0..P-1 (P = latched period, min 1); WG_START asserted for timer==0; each strobe increments PULSE_CNT.
- ARMED: EXT_TRIG rising edge (EXT_TRIG=1, previous sample 0) -> strobe, increment PULSE_CNT, go HOLDOFF. Edge-detect register updates in every state.
- HOLDOFF: count P cycles, edges ignored; then ARMED.
- Completion: after the strobe that makes PULSE_CNT == CFG_COUNT (CFG_COUNT≠0) -> IDLE, DONE strobe.
- CFG_COUNT=0: run until CMD_STOP; PULSE_CNT wraps max→0.
- CMD_STOP: any state -> IDLE next cycle; no DONE; no further WG_START. CMD_STOP wins over simultaneous CMD_START. Strobe already scheduled in the same cycle as CMD_STOP is suppressed.
- CMD_START while BUSY: ignored.
- Period shorter than generator pulse width: allowed; generator retriggers and holds high.

## Timing

- All outputs registered. Reset values: WG_START 0, BUSY 0, DONE 0, PULSE_CNT 0, state IDLE, edge register 0.
- CMD_START sampled at cycle n: BUSY=1 at n+1; internal mode first WG_START at n+1, subsequent at n+1+k·P.
- External mode: edge sampled at cycle m (in ARMED) -> WG_START at m+1; next edge accepted no earlier than sample m+1+P.
- Last strobe at cycle k -> DONE=1, BUSY=0 at k+1. PULSE_CNT holds final value until next CMD_START.
- CMD_STOP sampled at n -> BUSY=0 at n+1.
- RST mid-run: all outputs to reset values next cycle; in-flight strobe dropped.

## Structure

- Shared package: state enum (IDLE, RUN_INT, ARMED, HOLDOFF), constant MIN_PERIOD = 1.
- One sub-module: period_timer (load/enable, counts to latched P, terminal-count flag), reused by RUN_INT and HOLDOFF.
- Edge detect and FSM in top level.

## Test plan

- Internal, P=4, COUNT=3, CMD_START at cycle 10 -> WG_START at 11, 15, 19; DONE and BUSY=0 at 20; PULSE_CNT=3.
- Internal, P=0, COUNT=2 -> WG_START at n+1, n+2; DONE at n+3.
- External, P=5, COUNT=2; EXT_TRIG edges at cycles 20, 22, 30 -> WG_START at 21 and 31 only; edge at 22 ignored; DONE at 32.
- Continuous (COUNT=0), P=3, CMD_STOP sampled on a scheduled-strobe cycle -> that strobe suppressed, BUSY=0 next cycle, no DONE, PULSE_CNT holds.
- CMD_START and CMD_STOP same cycle in IDLE -> stays IDLE; CMD_START while BUSY -> ignored, timing unchanged.
- RST asserted mid-run with COUNT=10 -> next cycle all outputs 0, state IDLE; fresh CMD_START runs normally.

Source files
------------

// File: rtl/pulse_train_sequencer_pkg.sv
// Shared types and constants for the pulse train sequencer and its period timer.
package pulse_train_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRunInt,
    StArmed,
    StHoldoff
  } state_e;

  localparam int unsigned MIN_PERIOD = 1;

endpackage

// File: rtl/pulse_train_sequencer_if.sv
// Configuration, command and status bundle between the control registers and the sequencer.
interface pulse_train_sequencer_if #(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH  = 16
);

  logic [PERIOD_WIDTH-1:0] CFG_PERIOD;
  logic [COUNT_WIDTH-1:0]  CFG_COUNT;
  logic                    CFG_EXT;
  logic                    CMD_START;
  logic                    CMD_STOP;
  logic                    BUSY;
  logic                    DONE;
  logic [COUNT_WIDTH-1:0]  PULSE_CNT;

  modport master (
    output CFG_PERIOD, CFG_COUNT, CFG_EXT, CMD_START, CMD_STOP,
    input  BUSY, DONE, PULSE_CNT
  );

  modport slave (
    input  CFG_PERIOD, CFG_COUNT, CFG_EXT, CMD_START, CMD_STOP,
    output BUSY, DONE, PULSE_CNT
  );

endinterface

// File: rtl/pulse_train_sequencer_period_timer.sv
// Free-running modulo-P counter; tc flags the last count of each period (P = 0 behaves as P = 1).
module pulse_train_sequencer_period_timer
  import pulse_train_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] last;

  always_comb begin
    last = (period == '0) ? WIDTH'(MIN_PERIOD - 1) : period - WIDTH'(1);
    tc   = (count_q == last);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tc ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_train_sequencer.sv
// Issues START strobes to the pulse generator on an internal period or on external trigger
// edges with holdoff, for a programmed pulse count or continuously.
module pulse_train_sequencer
  import pulse_train_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  pulse_train_sequencer_if.slave bus,
  input  logic                   EXT_TRIG,
  output logic                   WG_START
);

  state_e                  state_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [COUNT_WIDTH-1:0]  count_q;
  logic [COUNT_WIDTH-1:0]  pulse_cnt_q;
  logic                    trig_q;
  logic                    wg_start_q;
  logic                    busy_q;
  logic                    done_q;

  logic start_ok;
  logic trig_rise;
  logic last_hit;
  logic timer_load;
  logic timer_en;
  logic timer_tc;

  always_comb begin
    start_ok   = bus.CMD_START && !bus.CMD_STOP;
    trig_rise  = EXT_TRIG && !trig_q;
    last_hit   = (count_q != '0) && (pulse_cnt_q == count_q);
    // Timer restarts on the strobe that opens a period or holdoff window.
    timer_load = ((state_q == StIdle) && start_ok) || ((state_q == StArmed) && trig_rise);
    timer_en   = (state_q == StRunInt) || (state_q == StHoldoff);
  end

  pulse_train_sequencer_period_timer #(
    .WIDTH(PERIOD_WIDTH)
  ) u_period_timer (
    .CLK   (CLK),
    .RST   (RST),
    .load  (timer_load),
    .en    (timer_en),
    .period(period_q),
    .tc    (timer_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      period_q    <= '0;
      count_q     <= '0;
      pulse_cnt_q <= '0;
      trig_q      <= 1'b0;
      wg_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      trig_q     <= EXT_TRIG;
      wg_start_q <= 1'b0;
      done_q     <= 1'b0;
      // Stop beats any strobe or start decided in the same cycle.
      if (bus.CMD_STOP) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.CMD_START) begin
              period_q <= bus.CFG_PERIOD;
              count_q  <= bus.CFG_COUNT;
              busy_q   <= 1'b1;
              if (bus.CFG_EXT) begin
                state_q     <= StArmed;
                pulse_cnt_q <= '0;
              end else begin
                state_q     <= StRunInt;
                wg_start_q  <= 1'b1;
                pulse_cnt_q <= COUNT_WIDTH'(1);
              end
            end
          end
          StRunInt: begin
            if (last_hit) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (timer_tc) begin
              wg_start_q  <= 1'b1;
              pulse_cnt_q <= pulse_cnt_q + COUNT_WIDTH'(1);
            end
          end
          StArmed: begin
            if (trig_rise) begin
              state_q     <= StHoldoff;
              wg_start_q  <= 1'b1;
              pulse_cnt_q <= pulse_cnt_q + COUNT_WIDTH'(1);
            end
          end
          StHoldoff: begin
            if (last_hit) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (timer_tc) begin
              state_q <= StArmed;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign WG_START      = wg_start_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PULSE_CNT = pulse_cnt_q;

endmodule
